// File: rtl/reservation_station_pkg.sv
// Shared types, sizes and operand-snoop helper for the ALU reservation station.
// Optional build macro RS_OLDEST_FIRST_EN adds age stamps and an age-compare helper.
package reservation_station_pkg;

  localparam int XLEN           = 32;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE        = 8;
  localparam int RS_SIZE_WIDTH  = 3;
  localparam int AGE_WIDTH      = RS_SIZE_WIDTH + 1;

  typedef logic [XLEN-1:0]           word_t;
  typedef logic [ROB_SIZE_WIDTH-1:0] robId_t;
  typedef logic [AGE_WIDTH-1:0]      age_t;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluOp_e;

  typedef struct packed {
    logic   hasDep;
    robId_t dep;
    word_t  val;
  } operand_t;

  typedef struct packed {
    logic     busy;
    aluOp_e   op;
    operand_t src1;
    operand_t src2;
    robId_t   id;
  } rsEntry_t;

  // ALU wins when both buses match; the ROB never puts the same id on both.
  function automatic operand_t snoopOperand(operand_t cur,
                                            logic aluRdy, robId_t aluId, word_t aluRes,
                                            logic lsbRdy, robId_t lsbId, word_t lsbRes);
    operand_t nxt;
    nxt = cur;
    if (cur.hasDep) begin
      if (aluRdy && aluId == cur.dep) begin
        nxt.val    = aluRes;
        nxt.hasDep = 1'b0;
      end else if (lsbRdy && lsbId == cur.dep) begin
        nxt.val    = lsbRes;
        nxt.hasDep = 1'b0;
      end
    end
    return nxt;
  endfunction

`ifdef RS_OLDEST_FIRST_EN
  // Stamps are one bit wider than the entry index, so a wrapped difference stays unambiguous.
  function automatic logic isOlder(age_t a, age_t b);
    age_t diff;
    diff = a - b;
    return diff[AGE_WIDTH-1];
  endfunction
`endif

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, broadcast-snoop and ALU-issue bundle around the reservation station.
// The station itself connects through the slave modport.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic   rdy;
  logic   flush;

  logic   dec_valid;
  aluOp_e dec_op;
  word_t  dec_val1;
  word_t  dec_val2;
  logic   dec_has_dep1;
  logic   dec_has_dep2;
  robId_t dec_dep1;
  robId_t dec_dep2;
  robId_t dec_id;
  logic   rs_full;

  logic   alu_ready;
  word_t  alu_res;
  robId_t alu_id;
  logic   lsb_ready;
  word_t  lsb_res;
  robId_t lsb_id;

  logic   rs_ready;
  aluOp_e rs_op;
  word_t  rs_val1;
  word_t  rs_val2;
  robId_t rs_id;

  modport slave (
    input  rdy, flush,
    input  dec_valid, dec_op, dec_val1, dec_val2, dec_has_dep1, dec_has_dep2,
    input  dec_dep1, dec_dep2, dec_id,
    output rs_full,
    input  alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
    output rs_ready, rs_op, rs_val1, rs_val2, rs_id
  );

  modport master (
    output rdy, flush,
    output dec_valid, dec_op, dec_val1, dec_val2, dec_has_dep1, dec_has_dep2,
    output dec_dep1, dec_dep2, dec_id,
    input  rs_full,
    output alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
    input  rs_ready, rs_op, rs_val1, rs_val2, rs_id
  );

endinterface

// File: rtl/reservation_station_rs_issue_select.sv
// Combinational pick of one ready entry: lowest index by default,
// oldest age stamp when RS_OLDEST_FIRST_EN is defined.
module rs_issue_select
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0]       ready_i,
`ifdef RS_OLDEST_FIRST_EN
  input  age_t                     age_i [RS_SIZE],
`endif
  output logic                     found_o,
  output logic [RS_SIZE_WIDTH-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_i[i]) begin
`ifdef RS_OLDEST_FIRST_EN
        if (!found_o || isOlder(age_i[i], age_i[idx_o])) begin
`else
        if (!found_o) begin
`endif
          found_o = 1'b1;
          idx_o   = RS_SIZE_WIDTH'(i);
        end
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: dispatch with forwarding, CDB wake-up, one registered issue per cycle.
// Build macro RS_OLDEST_FIRST_EN switches issue priority from lowest index to oldest dispatch.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  reservation_station_if.slave  rsBus
);

  rsEntry_t entries_q [RS_SIZE];
  rsEntry_t entries_d [RS_SIZE];
  logic     rsReady_q, rsReady_d;
  aluOp_e   rsOp_q, rsOp_d;
  word_t    rsVal1_q, rsVal1_d;
  word_t    rsVal2_q, rsVal2_d;
  robId_t   rsId_q, rsId_d;

`ifdef RS_OLDEST_FIRST_EN
  age_t     age_q [RS_SIZE];
  age_t     age_d [RS_SIZE];
  age_t     ageCnt_q, ageCnt_d;
`endif

  logic [RS_SIZE-1:0]       busyVec;
  logic [RS_SIZE-1:0]       readyVec;
  logic                     rsFull;
  logic [RS_SIZE_WIDTH-1:0] freeIdx;
  logic                     issueFound;
  logic [RS_SIZE_WIDTH-1:0] issueIdx;
  rsEntry_t                 newEntry;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busyVec[i]  = entries_q[i].busy;
      readyVec[i] = entries_q[i].busy && !entries_q[i].src1.hasDep && !entries_q[i].src2.hasDep;
    end
    rsFull = &busyVec;
  end

  always_comb begin
    freeIdx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busyVec[i]) freeIdx = RS_SIZE_WIDTH'(i);
    end
  end

  rs_issue_select u_select (
    .ready_i (readyVec),
`ifdef RS_OLDEST_FIRST_EN
    .age_i   (age_q),
`endif
    .found_o (issueFound),
    .idx_o   (issueIdx)
  );

  // Incoming op with same-cycle broadcast forwarding applied to each pending operand.
  always_comb begin
    newEntry.busy = 1'b1;
    newEntry.op   = rsBus.dec_op;
    newEntry.id   = rsBus.dec_id;
    newEntry.src1 = snoopOperand('{hasDep: rsBus.dec_has_dep1, dep: rsBus.dec_dep1, val: rsBus.dec_val1},
                                 rsBus.alu_ready, rsBus.alu_id, rsBus.alu_res,
                                 rsBus.lsb_ready, rsBus.lsb_id, rsBus.lsb_res);
    newEntry.src2 = snoopOperand('{hasDep: rsBus.dec_has_dep2, dep: rsBus.dec_dep2, val: rsBus.dec_val2},
                                 rsBus.alu_ready, rsBus.alu_id, rsBus.alu_res,
                                 rsBus.lsb_ready, rsBus.lsb_id, rsBus.lsb_res);
  end

  always_comb begin
    rsReady_d = rsReady_q;
    rsOp_d    = rsOp_q;
    rsVal1_d  = rsVal1_q;
    rsVal2_d  = rsVal2_q;
    rsId_d    = rsId_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d     = age_q;
    ageCnt_d  = ageCnt_q;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i]      = entries_q[i];
      entries_d[i].src1 = snoopOperand(entries_q[i].src1,
                                       rsBus.alu_ready, rsBus.alu_id, rsBus.alu_res,
                                       rsBus.lsb_ready, rsBus.lsb_id, rsBus.lsb_res);
      entries_d[i].src2 = snoopOperand(entries_q[i].src2,
                                       rsBus.alu_ready, rsBus.alu_id, rsBus.alu_res,
                                       rsBus.lsb_ready, rsBus.lsb_id, rsBus.lsb_res);
    end

    if (rsBus.flush) begin
      for (int i = 0; i < RS_SIZE; i++) entries_d[i].busy = 1'b0;
      rsReady_d = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
      ageCnt_d  = '0;
`endif
    end else begin
      rsReady_d = issueFound;
      if (issueFound) begin
        entries_d[issueIdx].busy = 1'b0;
        rsOp_d   = entries_q[issueIdx].op;
        rsVal1_d = entries_q[issueIdx].src1.val;
        rsVal2_d = entries_q[issueIdx].src2.val;
        rsId_d   = entries_q[issueIdx].id;
      end
      // The free slot is never the issue slot, so both writes can land on one edge.
      if (rsBus.dec_valid && !rsFull) begin
        entries_d[freeIdx] = newEntry;
`ifdef RS_OLDEST_FIRST_EN
        age_d[freeIdx] = ageCnt_q;
        ageCnt_d       = ageCnt_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
      rsReady_q <= 1'b0;
      rsOp_q    <= ALU_ADD;
      rsVal1_q  <= '0;
      rsVal2_q  <= '0;
      rsId_q    <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
      ageCnt_q  <= '0;
`endif
    end else if (rsBus.rdy) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
      rsReady_q <= rsReady_d;
      rsOp_q    <= rsOp_d;
      rsVal1_q  <= rsVal1_d;
      rsVal2_q  <= rsVal2_d;
      rsId_q    <= rsId_d;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= age_d[i];
      ageCnt_q  <= ageCnt_d;
`endif
    end
  end

  assign rsBus.rs_full  = rsFull;
  assign rsBus.rs_ready = rsReady_q;
  assign rsBus.rs_op    = rsOp_q;
  assign rsBus.rs_val1  = rsVal1_q;
  assign rsBus.rs_val2  = rsVal2_q;
  assign rsBus.rs_id    = rsId_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, dispatch/issue latency, wake-up,
// forwarding, full boundary, flush, rdy stall and asynchronous reset mid-operation.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectorsApplied = 0;
  int   miscompares = 0;

  reservation_station_if rsBus ();

  reservation_station dut (
    .clk   (clk),
    .rst   (rst),
    .rsBus (rsBus)
  );

  always #5 clk = ~clk;

  task automatic idleInputs();
    rsBus.rdy          = 1'b1;
    rsBus.flush        = 1'b0;
    rsBus.dec_valid    = 1'b0;
    rsBus.dec_op       = ALU_ADD;
    rsBus.dec_val1     = '0;
    rsBus.dec_val2     = '0;
    rsBus.dec_has_dep1 = 1'b0;
    rsBus.dec_has_dep2 = 1'b0;
    rsBus.dec_dep1     = '0;
    rsBus.dec_dep2     = '0;
    rsBus.dec_id       = '0;
    rsBus.alu_ready    = 1'b0;
    rsBus.alu_res      = '0;
    rsBus.alu_id       = '0;
    rsBus.lsb_ready    = 1'b0;
    rsBus.lsb_res      = '0;
    rsBus.lsb_id       = '0;
  endtask

  task automatic driveDispatch(input aluOp_e op, input word_t v1, input word_t v2,
                               input logic hd1, input robId_t d1,
                               input logic hd2, input robId_t d2, input robId_t id);
    rsBus.dec_valid    = 1'b1;
    rsBus.dec_op       = op;
    rsBus.dec_val1     = v1;
    rsBus.dec_val2     = v2;
    rsBus.dec_has_dep1 = hd1;
    rsBus.dec_dep1     = d1;
    rsBus.dec_has_dep2 = hd2;
    rsBus.dec_dep2     = d2;
    rsBus.dec_id       = id;
  endtask

  // One active edge, then settle 1ns past it before anything is sampled or driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorsApplied++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset rs_ready", 64'(rsBus.rs_ready), 64'd0);
    checkOutput("reset rs_full", 64'(rsBus.rs_full), 64'd0);
    checkOutput("reset rs_op", 64'(rsBus.rs_op), 64'd0);
    checkOutput("reset rs_val1", 64'(rsBus.rs_val1), 64'd0);
    checkOutput("reset rs_val2", 64'(rsBus.rs_val2), 64'd0);
    checkOutput("reset rs_id", 64'(rsBus.rs_id), 64'd0);
    rst = 1'b0;

    $display("[TB] ready dispatch");
    driveDispatch(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    applyStimulus();
    idleInputs();
    checkOutput("ready dispatch not yet issued", 64'(rsBus.rs_ready), 64'd0);
    applyStimulus();
    checkOutput("ready issue rs_ready", 64'(rsBus.rs_ready), 64'd1);
    checkOutput("ready issue rs_op", 64'(rsBus.rs_op), 64'(ALU_ADD));
    checkOutput("ready issue rs_val1", 64'(rsBus.rs_val1), 64'd5);
    checkOutput("ready issue rs_val2", 64'(rsBus.rs_val2), 64'd7);
    checkOutput("ready issue rs_id", 64'(rsBus.rs_id), 64'd3);
    rsBus.alu_ready = 1'b1;
    rsBus.alu_res   = 32'd12;
    rsBus.alu_id    = 4'd3;
    applyStimulus();
    idleInputs();
    checkOutput("idle after single issue", 64'(rsBus.rs_ready), 64'd0);

    $display("[TB] dependency wake-up");
    driveDispatch(ALU_SUB, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("pending entry not issued", 64'(rsBus.rs_ready), 64'd0);
    rsBus.alu_ready = 1'b1;
    rsBus.alu_res   = 32'd12;
    rsBus.alu_id    = 4'd3;
    applyStimulus();
    idleInputs();
    checkOutput("no issue on wake edge", 64'(rsBus.rs_ready), 64'd0);
    applyStimulus();
    checkOutput("wake issue rs_ready", 64'(rsBus.rs_ready), 64'd1);
    checkOutput("wake issue rs_op", 64'(rsBus.rs_op), 64'(ALU_SUB));
    checkOutput("wake issue rs_val1", 64'(rsBus.rs_val1), 64'd12);
    checkOutput("wake issue rs_val2", 64'(rsBus.rs_val2), 64'd1);
    checkOutput("wake issue rs_id", 64'(rsBus.rs_id), 64'd4);

    $display("[TB] same-cycle forwarding");
    driveDispatch(ALU_XOR, 32'd2, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
    rsBus.lsb_ready = 1'b1;
    rsBus.lsb_id    = 4'd6;
    rsBus.lsb_res   = 32'hDEAD;
    applyStimulus();
    idleInputs();
    checkOutput("forward gap after wake issue", 64'(rsBus.rs_ready), 64'd0);
    applyStimulus();
    checkOutput("forward issue rs_ready", 64'(rsBus.rs_ready), 64'd1);
    checkOutput("forward issue rs_val1", 64'(rsBus.rs_val1), 64'd2);
    checkOutput("forward issue rs_val2", 64'(rsBus.rs_val2), 64'hDEAD);
    checkOutput("forward issue rs_id", 64'(rsBus.rs_id), 64'd5);

    $display("[TB] full boundary");
    for (int i = 0; i < RS_SIZE; i++) begin
      driveDispatch(ALU_OR, 32'd0, word_t'(i), 1'b1, 4'd9, 1'b0, 4'd0, robId_t'(i));
      applyStimulus();
    end
    idleInputs();
    checkOutput("full rs_full", 64'(rsBus.rs_full), 64'd1);
    checkOutput("full no issue", 64'(rsBus.rs_ready), 64'd0);
    driveDispatch(ALU_AND, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    applyStimulus();
    idleInputs();
    checkOutput("full still full after extra dispatch", 64'(rsBus.rs_full), 64'd1);
    rsBus.alu_ready = 1'b1;
    rsBus.alu_res   = 32'h99;
    rsBus.alu_id    = 4'd9;
    applyStimulus();
    idleInputs();
    checkOutput("full no issue on wake edge", 64'(rsBus.rs_ready), 64'd0);
    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus();
      checkOutput($sformatf("drain %0d rs_ready", i), 64'(rsBus.rs_ready), 64'd1);
      checkOutput($sformatf("drain %0d rs_id", i), 64'(rsBus.rs_id), 64'(i));
      checkOutput($sformatf("drain %0d rs_val1", i), 64'(rsBus.rs_val1), 64'h99);
      checkOutput($sformatf("drain %0d rs_val2", i), 64'(rsBus.rs_val2), 64'(i));
      if (i == 0) checkOutput("rs_full drops after first issue", 64'(rsBus.rs_full), 64'd0);
    end
    applyStimulus();
    checkOutput("dropped dispatch never issues", 64'(rsBus.rs_ready), 64'd0);

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) begin
      driveDispatch(ALU_SLL, 32'd0, 32'd3, 1'b1, 4'd10, 1'b0, 4'd0, robId_t'(i));
      applyStimulus();
    end
    idleInputs();
    checkOutput("pre-flush no issue", 64'(rsBus.rs_ready), 64'd0);
    rsBus.flush = 1'b1;
    driveDispatch(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    applyStimulus();
    idleInputs();
    checkOutput("flush rs_ready", 64'(rsBus.rs_ready), 64'd0);
    checkOutput("flush rs_full", 64'(rsBus.rs_full), 64'd0);
    checkOutput("flush holds rs_id", 64'(rsBus.rs_id), 64'd7);
    rsBus.alu_ready = 1'b1;
    rsBus.alu_res   = 32'h55;
    rsBus.alu_id    = 4'd10;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("post-flush no issue 1", 64'(rsBus.rs_ready), 64'd0);
    applyStimulus();
    checkOutput("post-flush no issue 2", 64'(rsBus.rs_ready), 64'd0);

    $display("[TB] rdy low stall");
    rsBus.rdy = 1'b0;
    driveDispatch(ALU_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("rdy low no issue", 64'(rsBus.rs_ready), 64'd0);
    checkOutput("rdy low holds rs_id", 64'(rsBus.rs_id), 64'd7);
    idleInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("rdy low dispatch not captured", 64'(rsBus.rs_ready), 64'd0);

    $display("[TB] async reset mid-operation");
    driveDispatch(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd1);
    applyStimulus();
    driveDispatch(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd2);
    applyStimulus();
    driveDispatch(ALU_SLT, 32'd8, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    applyStimulus();
    driveDispatch(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd3);
    applyStimulus();
    idleInputs();
    checkOutput("pre-reset issue rs_ready", 64'(rsBus.rs_ready), 64'd1);
    checkOutput("pre-reset issue rs_id", 64'(rsBus.rs_id), 64'd6);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset rs_ready", 64'(rsBus.rs_ready), 64'd0);
    checkOutput("async reset rs_full", 64'(rsBus.rs_full), 64'd0);
    checkOutput("async reset rs_id", 64'(rsBus.rs_id), 64'd0);
    checkOutput("async reset rs_val1", 64'(rsBus.rs_val1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsBus.alu_ready = 1'b1;
    rsBus.alu_res   = 32'h77;
    rsBus.alu_id    = 4'd11;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("reset cleared entries", 64'(rsBus.rs_ready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
